hazard_stall_unit: RTL and testbench

- Generates the hold, flush and bubble controls consumed by the PC register, IF/ID and ID/EX pipeline registers of the 5-stage MIPS pipeline.
- Detects load-use hazards and taken-branch/jump flushes.
- Tracks a fixed-latency multiply/divide unit and stalls HI/LO readers and back-to-back mult/div operations until it is done.
- PCWrite keeps its existing codebase polarity: 1 = hold PC, 0 = load PCNext.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_stall_unit_if.sv | 53 +++++
 rtl/muldiv_busy_tracker.sv | 62 ++++++
 rtl/hazard_stall_unit.sv | 72 +++++++
 tb/tb_hazard_stall_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants used by the PC, IF/ID and hazard logic.
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0]  REG_ZERO               = 5'd0;
  localparam int unsigned MULDIV_LATENCY_DEFAULT = 4;

  // PCWrite polarity shared with the PC register: 1 holds the current PC.
  localparam logic        PC_HOLD                = 1'b1;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit; StallCycles/FlushCycles exist only
// when HAZARD_STATS_EN is defined.
interface hazard_stall_unit_if;

  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IFID_ReadsHiLo;
  logic        IFID_IsMulDiv;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        IDEX_IsMulDiv;
  logic        BranchTaken;
  logic        Jump;

  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        MDBusy;

`ifdef HAZARD_STATS_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCycles;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv,
    output IDEX_MemRead, IDEX_Rt, IDEX_IsMulDiv, BranchTaken, Jump,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy,
    input  StallCycles, FlushCycles
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv,
    input  IDEX_MemRead, IDEX_Rt, IDEX_IsMulDiv, BranchTaken, Jump,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy,
    output StallCycles, FlushCycles
  );
`else
  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv,
    output IDEX_MemRead, IDEX_Rt, IDEX_IsMulDiv, BranchTaken, Jump,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv,
    input  IDEX_MemRead, IDEX_Rt, IDEX_IsMulDiv, BranchTaken, Jump,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy
  );
`endif

endinterface

// File: rtl/muldiv_busy_tracker.sv
// Tracks the fixed-latency mult/div unit: RUN/MD_BUSY FSM plus a down-counter driving MDBusy.
module muldiv_busy_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int unsigned CNT_W          = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_issue,
  output logic o_md_busy
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_LATENCY - 1);
  // With a one-cycle latency the MD_BUSY visit is bookkeeping only, not a busy cycle.
  localparam logic BusyInMdBusy = (MULDIV_LATENCY > 1);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (i_issue) begin
          w_state_next = MD_BUSY;
          w_cnt_next   = CntLoad;
        end
      end
      MD_BUSY: begin
        // A new issue always restarts the count, including the illegal mid-count case.
        if (i_issue) begin
          w_cnt_next = CntLoad;
        end else if (r_cnt == '0) begin
          w_state_next = RUN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_md_busy = ~Reset & (i_issue | ((r_state == MD_BUSY) & BusyInMdBusy));

endmodule

// File: rtl/hazard_stall_unit.sv
// Hold/flush/bubble generation for the 5-stage pipeline: load-use and HI/LO stalls, branch/jump
// flushes. HAZARD_STATS_EN adds free-running StallCycles/FlushCycles counters.
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int unsigned CNT_W          = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  hazard_stall_unit_if.slave  bus
);

  logic w_md_busy;
  logic w_load_use;
  logic w_hilo_stall;
  logic w_stall;
  logic w_flush;

  muldiv_busy_tracker #(
    .MULDIV_LATENCY (MULDIV_LATENCY),
    .CNT_W          (CNT_W)
  ) u_muldiv_busy_tracker (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_issue   (bus.IDEX_IsMulDiv),
    .o_md_busy (w_md_busy)
  );

  assign w_load_use = bus.IDEX_MemRead & (bus.IDEX_Rt != REG_ZERO) &
                      ((bus.IDEX_Rt == bus.IFID_Rs) |
                       (bus.IFID_UsesRt & (bus.IDEX_Rt == bus.IFID_Rt)));

  assign w_hilo_stall = w_md_busy & (bus.IFID_ReadsHiLo | bus.IFID_IsMulDiv);
  assign w_stall      = w_load_use | w_hilo_stall;
  // An operand-stalled branch has not really resolved yet, so the stall wins.
  assign w_flush      = (bus.BranchTaken | bus.Jump) & ~w_stall;

  always_comb begin
    bus.PCWrite    = ~PC_HOLD;
    bus.IFIDWrite  = 1'b0;
    bus.IFIDFlush  = 1'b1;
    bus.IDEXBubble = 1'b1;
    bus.MDBusy     = 1'b0;
    if (!Reset) begin
      bus.PCWrite    = w_stall ? PC_HOLD : ~PC_HOLD;
      bus.IFIDWrite  = w_stall;
      bus.IFIDFlush  = w_flush;
      bus.IDEXBubble = w_stall;
      bus.MDBusy     = w_md_busy;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush) r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign bus.StallCycles = r_stall_cycles;
  assign bus.FlushCycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a cycle-level reference model and literal spot checks.
module tb_hazard_stall_unit;

  localparam int unsigned Lat = 4;

  logic Clk;
  logic Reset;
  int   n_pass;
  int   n_total;

  hazard_stall_unit_if bus ();

  hazard_stall_unit #(
    .MULDIV_LATENCY (Lat),
    .CNT_W          (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Reference model: cycles of mult/div busy still owed after the current one.
  int          m_left;
  longint      m_stalls;
  longint      m_flushes;

  function automatic bit m_busy();
    return !Reset && (bus.IDEX_IsMulDiv || m_left > 0);
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = bus.IDEX_MemRead && bus.IDEX_Rt != 0 &&
         (bus.IDEX_Rt == bus.IFID_Rs || (bus.IFID_UsesRt && bus.IDEX_Rt == bus.IFID_Rt));
    return lu || (m_busy() && (bus.IFID_ReadsHiLo || bus.IFID_IsMulDiv));
  endfunction

  function automatic bit m_flush();
    return (bus.BranchTaken || bus.Jump) && !m_stall();
  endfunction

  initial begin
    m_left = 0; m_stalls = 0; m_flushes = 0;
  end

  always @(posedge Clk) begin
    if (Reset) begin
      m_left = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_stalls  = m_stalls + longint'(m_stall());
      m_flushes = m_flushes + longint'(m_flush());
      if (bus.IDEX_IsMulDiv) m_left = Lat;
      else if (m_left > 0)   m_left = m_left - 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (Reset) begin
      check("model_pcwrite", bus.PCWrite, 0);
      check("model_ifidflush", bus.IFIDFlush, 1);
      check("model_bubble", bus.IDEXBubble, 1);
      check("model_mdbusy", bus.MDBusy, 0);
    end else begin
      check("model_pcwrite", bus.PCWrite, m_stall());
      check("model_ifidwrite", bus.IFIDWrite, m_stall());
      check("model_bubble", bus.IDEXBubble, m_stall());
      check("model_ifidflush", bus.IFIDFlush, m_flush());
      check("model_mdbusy", bus.MDBusy, m_busy());
    end
`ifdef HAZARD_STATS_EN
    check("model_stallcycles", bus.StallCycles, m_stalls % 64'h1_0000_0000);
    check("model_flushcycles", bus.FlushCycles, m_flushes % 64'h1_0000_0000);
`endif
  end

  task automatic idle_inputs();
    bus.IFID_Rs = 5'd0; bus.IFID_Rt = 5'd0; bus.IFID_UsesRt = 1'b0;
    bus.IFID_ReadsHiLo = 1'b0; bus.IFID_IsMulDiv = 1'b0;
    bus.IDEX_MemRead = 1'b0; bus.IDEX_Rt = 5'd0; bus.IDEX_IsMulDiv = 1'b0;
    bus.BranchTaken = 1'b0; bus.Jump = 1'b0;
  endtask

  task automatic to_sample();
    @(negedge Clk);
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    Reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();

    // Reset outputs
    to_sample();
    check("rst_pcwrite", bus.PCWrite, 0);
    check("rst_ifidwrite", bus.IFIDWrite, 0);
    check("rst_flush", bus.IFIDFlush, 1);
    check("rst_bubble", bus.IDEXBubble, 1);
    check("rst_mdbusy", bus.MDBusy, 0);
    next_cycle();
    Reset = 1'b0;

    // Load-use on rs, then bubble clears MemRead
    bus.IDEX_MemRead = 1'b1; bus.IDEX_Rt = 5'd8; bus.IFID_Rs = 5'd8;
    to_sample();
    check("lu_rs_pcwrite", bus.PCWrite, 1);
    check("lu_rs_ifidwrite", bus.IFIDWrite, 1);
    check("lu_rs_bubble", bus.IDEXBubble, 1);
    next_cycle();
    bus.IDEX_MemRead = 1'b0;
    to_sample();
    check("lu_after_pcwrite", bus.PCWrite, 0);
    check("lu_after_ifidwrite", bus.IFIDWrite, 0);
    check("lu_after_bubble", bus.IDEXBubble, 0);
    next_cycle();

    // Register zero and unused rt
    bus.IDEX_MemRead = 1'b1; bus.IDEX_Rt = 5'd0; bus.IFID_Rs = 5'd0;
    to_sample();
    check("lu_zero_reg", bus.PCWrite, 0);
    next_cycle();
    bus.IDEX_Rt = 5'd9; bus.IFID_Rs = 5'd3; bus.IFID_Rt = 5'd9; bus.IFID_UsesRt = 1'b0;
    to_sample();
    check("lu_rt_unused", bus.PCWrite, 0);
    next_cycle();
    bus.IFID_UsesRt = 1'b1;
    to_sample();
    check("lu_rt_used", bus.IDEXBubble, 1);
    next_cycle();

    // Stall beats branch; then a clean branch flushes
    bus.BranchTaken = 1'b1;
    to_sample();
    check("br_stall_flush", bus.IFIDFlush, 0);
    check("br_stall_pcwrite", bus.PCWrite, 1);
    next_cycle();
    bus.IDEX_MemRead = 1'b0;
    to_sample();
    check("br_flush", bus.IFIDFlush, 1);
    check("br_pcwrite", bus.PCWrite, 0);
    next_cycle();
    idle_inputs();
    bus.Jump = 1'b1;
    to_sample();
    check("jump_flush", bus.IFIDFlush, 1);
    next_cycle();
    idle_inputs();

    // Mult/div issue at t, mfhi held: busy t..t+4, released t+5
    bus.IDEX_IsMulDiv = 1'b1; bus.IFID_ReadsHiLo = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      to_sample();
      check("md_busy", bus.MDBusy, (k <= 4) ? 1 : 0);
      check("md_pc_hold", bus.PCWrite, (k <= 4) ? 1 : 0);
      next_cycle();
      bus.IDEX_IsMulDiv = 1'b0;
    end
    idle_inputs();

    // Back-to-back mult/div in ID while busy, plus an illegal mid-count re-issue
    bus.IDEX_IsMulDiv = 1'b1;
    next_cycle();
    bus.IDEX_IsMulDiv = 1'b0; bus.IFID_IsMulDiv = 1'b1;
    to_sample();
    check("md_b2b_stall", bus.PCWrite, 1);
    next_cycle();
    bus.IDEX_IsMulDiv = 1'b1; bus.IFID_IsMulDiv = 1'b0;
    next_cycle();
    bus.IDEX_IsMulDiv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      to_sample();
      check("md_restart_busy", bus.MDBusy, (k <= 4) ? 1 : 0);
      next_cycle();
    end
    idle_inputs();

    // Reset two cycles after issue aborts tracking
    bus.IDEX_IsMulDiv = 1'b1; bus.IFID_ReadsHiLo = 1'b1;
    next_cycle();
    bus.IDEX_IsMulDiv = 1'b0;
    next_cycle();
    Reset = 1'b1;
    to_sample();
    check("midrst_mdbusy", bus.MDBusy, 0);
    check("midrst_flush", bus.IFIDFlush, 1);
    next_cycle();
    Reset = 1'b0;
    to_sample();
    check("postrst_mdbusy", bus.MDBusy, 0);
    check("postrst_pcwrite", bus.PCWrite, 0);
    next_cycle();
    idle_inputs();

`ifdef HAZARD_STATS_EN
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    bus.IDEX_MemRead = 1'b1; bus.IDEX_Rt = 5'd8; bus.IFID_Rs = 5'd8;
    for (int k = 0; k < 3; k++) next_cycle();
    idle_inputs();
    bus.BranchTaken = 1'b1;
    for (int k = 0; k < 2; k++) next_cycle();
    idle_inputs();
    to_sample();
    check("stats_stalls", bus.StallCycles, 3);
    check("stats_flushes", bus.FlushCycles, 2);
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    to_sample();
    check("stats_clr_stalls", bus.StallCycles, 0);
    check("stats_clr_flushes", bus.FlushCycles, 0);
    next_cycle();
`endif

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
